// File: rtl/bcd_updown_counter.sv
// Purpose : multi-digit BCD up/down counter stepped by rising edges of the
//           divider output clk_div, which is sampled as data in the clk domain.
// Latency : count/step_o/wrap update SYNC_STAGES clk edges after clk_div is
//           first sampled high; load takes effect on the next clk edge.
// Backpressure: none. Steps seen while en=0, or coincident with load, are dropped.
//
// Ports:
//   clk      - 50 MHz system clock, rising edge; the only clock in this block
//   rst      - asynchronous, active-high reset
//   clk_div  - divided square wave (data, not a clock); each 0->1 is one step
//   en       - count enable, sampled on the step cycle
//   up       - direction, 1 = increment, 0 = decrement, sampled on the step cycle
//   load     - synchronous load, wins over a coincident step
//   load_val - packed BCD load value, digit 0 in [3:0]; digits above 9 clamp to 9
//   count    - packed BCD count, registered
//   step_o   - one-cycle pulse in the cycle after a step was applied
//   wrap     - one-cycle pulse when a step rolled 9..9 -> 0..0 or 0..0 -> 9..9

module bcd_updown_counter #(
   parameter int DIGITS      = 4,
   parameter int SYNC_STAGES = 2   // must be at least 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_div,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  step_o,
   output logic                  wrap
);

   localparam int W = 4 * DIGITS;

   // ------------------------------------------------------------------
   // Synchroniser and rising-edge detect.
   // Everything resets to 1 so that a clk_div already high when reset is
   // released looks like "no change"; a genuine 0->1 is needed to step.
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   step_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], clk_div};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // High for exactly one clk cycle per synchronised rising edge.
   assign step_req = sync_q[SYNC_STAGES-1] & ~prev_q;

   // ------------------------------------------------------------------
   // Next count for a step. A ripple flag walks up the digits: for counting
   // up it stays set while every lower digit was 9, for counting down while
   // every lower digit was 0. Whatever survives past the top digit means
   // the whole count rolled over.
   // ------------------------------------------------------------------
   logic [W-1:0] stepped;
   logic         ripple;
   logic [3:0]   dig;

   always_comb begin
      stepped = count;
      ripple  = 1'b1;
      dig     = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         dig = count[4*i +: 4];
         if (up) begin
            if (ripple) begin
               stepped[4*i +: 4] = (dig >= 4'd9) ? 4'd0 : dig + 4'd1;
            end
            ripple = ripple & (dig == 4'd9);
         end else begin
            if (ripple) begin
               stepped[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end
            ripple = ripple & (dig == 4'd0);
         end
      end
   end

   // ------------------------------------------------------------------
   // Load value with every digit forced into 0..9 so the count can never
   // hold a non-BCD digit.
   // ------------------------------------------------------------------
   logic [W-1:0] clamped;
   logic [3:0]   ld_dig;

   always_comb begin
      clamped = '0;
      ld_dig  = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         ld_dig = load_val[4*i +: 4];
         clamped[4*i +: 4] = (ld_dig > 4'd9) ? 4'd9 : ld_dig;
      end
   end

   // ------------------------------------------------------------------
   // Count register: load beats step; a step needs en. Any step_req not
   // taken here is gone for good, it is never held over.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         step_o <= 1'b0;
         wrap   <= 1'b0;
      end else if (load) begin
         count  <= clamped;
         step_o <= 1'b0;
         wrap   <= 1'b0;
      end else if (step_req && en) begin
         count  <= stepped;
         step_o <= 1'b1;
         wrap   <= ripple;
      end else begin
         step_o <= 1'b0;
         wrap   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter (DIGITS=4, SYNC_STAGES=2).
// Expected counts come from an integer-arithmetic model and are queued when
// a clk_div edge is driven, then popped when the DUT pulses step_o.

module tb_bcd_updown_counter;

   logic        clk;
   logic        rst;
   logic        clk_div;
   logic        en;
   logic        up;
   logic        load;
   logic [15:0] load_val;
   logic [15:0] count;
   logic        step_o;
   logic        wrap;

   bcd_updown_counter #(.DIGITS(4), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .clk_div  (clk_div),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .step_o   (step_o),
      .wrap     (wrap)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct packed {
      logic [15:0] cnt;
      logic        wrp;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] m_count;
   int          n_vec;
   int          n_err;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int bcd2int(input logic [15:0] b);
      int v;
      v = 0;
      for (int i = 3; i >= 0; i--) v = v * 10 + int'((b >> (4 * i)) & 16'hF);
      return v;
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] b;
      int          t;
      b = '0;
      t = v;
      for (int i = 0; i < 4; i++) begin
         b = b | (16'(t % 10) << (4 * i));
         t = t / 10;
      end
      return b;
   endfunction

   function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
      int d;
      int s;
      s = 0;
      for (int i = 3; i >= 0; i--) begin
         d = int'((v >> (4 * i)) & 16'hF);
         if (d > 9) d = 9;
         s = s * 10 + d;
      end
      return int2bcd(s);
   endfunction

   // Drive one clk_div period (high 6 cycles, low 4) and check what comes out.
   task automatic do_edge(input string tag);
      exp_t e;
      int   v;
      int   seen;
      int   lat;
      int   bad_wrap;
      bit   want;
      want = en;
      seen = 0;
      lat = -1;
      bad_wrap = 0;
      if (want) begin
         v = bcd2int(m_count);
         if (up) begin
            e.wrp = (v == 9999);
            v = (v + 1) % 10000;
         end else begin
            e.wrp = (v == 0);
            v = (v + 9999) % 10000;
         end
         e.cnt = int2bcd(v);
         m_count = e.cnt;
         sb.push_back(e);
      end
      clk_div = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         if (c == 7) clk_div = 1'b0;
         tick();
         if (step_o) begin
            seen++;
            if (lat < 0) lat = c;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check({tag, " count"}, 32'(count), 32'(e.cnt));
               check({tag, " wrap"}, 32'(wrap), 32'(e.wrp));
            end
         end else if (wrap) begin
            bad_wrap++;
         end
      end
      check({tag, " steps"}, seen, want ? 1 : 0);
      if (want) check({tag, " latency"}, lat, 3);
      check({tag, " hold"}, 32'(count), 32'(m_count));
      check({tag, " stray wrap"}, bad_wrap, 0);
   endtask

   task automatic do_load(input string tag, input logic [15:0] v);
      load     = 1'b1;
      load_val = v;
      tick();
      load     = 1'b0;
      m_count  = clamp_bcd(v);
      check({tag, " count"}, 32'(count), 32'(m_count));
      check({tag, " step_o"}, 32'(step_o), 32'(0));
   endtask

   // Hold inputs for n cycles and report how many step_o pulses appeared.
   task automatic idle(input int n, output int steps);
      steps = 0;
      for (int c = 0; c < n; c++) begin
         tick();
         if (step_o) steps++;
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int steps;
      n_vec    = 0;
      n_err    = 0;
      m_count  = '0;
      rst      = 1'b1;
      clk_div  = 1'b1;
      en       = 1'b1;
      up       = 1'b1;
      load     = 1'b0;
      load_val = '0;

      // Reset with clk_div high; no step until a real 0->1.
      repeat (3) tick();
      check("reset count", 32'(count), 32'h0);
      check("reset step_o", 32'(step_o), 32'(0));
      check("reset wrap", 32'(wrap), 32'(0));
      rst = 1'b0;
      idle(10, steps);
      check("post-reset high steps", steps, 0);
      check("post-reset high count", 32'(count), 32'h0);
      clk_div = 1'b0;
      idle(4, steps);
      do_edge("first edge");

      // Up across digit boundaries.
      do_load("load 0998", 16'h0998);
      do_edge("up 0999");
      do_edge("up 1000");
      do_edge("up 1001");

      // Rollover both ways.
      do_load("load 9999", 16'h9999);
      do_edge("up wrap");
      up = 1'b0;
      do_edge("down wrap");

      // Down with borrow, then dropped steps under en=0.
      do_load("load 1000", 16'h1000);
      do_edge("down 0999");
      en = 1'b0;
      for (int i = 0; i < 5; i++) do_edge("en off");
      en = 1'b1;
      do_edge("down 0998");

      // Load coincident with step_req, with clamped digits.
      clk_div = 1'b1;
      tick();
      tick();
      load     = 1'b1;
      load_val = 16'h12AF;
      tick();
      load     = 1'b0;
      m_count  = 16'h1299;
      check("collide count", 32'(count), 32'h1299);
      check("collide step_o", 32'(step_o), 32'(0));
      check("collide wrap", 32'(wrap), 32'(0));
      idle(4, steps);
      clk_div = 1'b0;
      begin
         int s2;
         idle(4, s2);
         steps += s2;
      end
      check("collide no late step", steps, 0);
      check("collide hold", 32'(count), 32'h1299);

      // Reset while an edge is in the synchroniser.
      up = 1'b1;
      do_load("load 0456", 16'h0456);
      clk_div = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("async rst count", 32'(count), 32'h0);
      check("async rst step_o", 32'(step_o), 32'(0));
      tick();
      tick();
      rst = 1'b0;
      m_count = '0;
      idle(6, steps);
      check("rst no stale step", steps, 0);
      check("rst hold count", 32'(count), 32'h0);
      clk_div = 1'b0;
      idle(4, steps);
      check("rst low no step", steps, 0);
      do_edge("after rst edge");

      check("scoreboard drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
